// File: rtl/tx_edge_hist_pkg.sv
// Shared types and default sizing for the transmit edge history feeding the pwl step evaluators.
package tx_edge_hist_pkg;

    localparam int EDGE_HIST_DEPTH = 8;
    localparam int EDGE_TIME_WIDTH = 32;
    localparam int EDGE_DT_WIDTH   = 20;
    localparam int EDGE_SYM_WIDTH  = 2;
    localparam logic [EDGE_TIME_WIDTH-1:0] EDGE_DT_MAX = EDGE_TIME_WIDTH'((1 << 20) - 1);

    typedef struct packed {
        logic [EDGE_TIME_WIDTH-1:0]   stamp;
        logic signed [EDGE_SYM_WIDTH:0] weight;
        logic                         valid;
    } edge_entry_t;

    function automatic logic signed [EDGE_SYM_WIDTH:0] step_weight(
        input logic [EDGE_SYM_WIDTH-1:0] new_sym,
        input logic [EDGE_SYM_WIDTH-1:0] old_sym
    );
        return $signed({1'b0, new_sym}) - $signed({1'b0, old_sym});
    endfunction

endpackage

// File: rtl/tx_edge_hist_if.sv
// Symbol/time inputs and per-tap history outputs of the transmit edge history.
interface tx_edge_hist_if
    import tx_edge_hist_pkg::*;
#(
    parameter int DEPTH    = EDGE_HIST_DEPTH,
    parameter int DT_WIDTH = EDGE_DT_WIDTH
) ();

    logic [EDGE_TIME_WIDTH-1:0]            time_now;
    logic [EDGE_SYM_WIDTH-1:0]             sym_in;
    logic                                  sym_valid;
    logic [DEPTH*DT_WIDTH-1:0]             dt_out;
    logic [DEPTH*(EDGE_SYM_WIDTH+1)-1:0]   weight_out;
    logic [DEPTH-1:0]                      tap_valid;
    logic [$clog2(DEPTH+1)-1:0]            n_live;
    logic                                  overflow;

    modport master (
        output time_now, sym_in, sym_valid,
        input  dt_out, weight_out, tap_valid, n_live, overflow
    );

    modport slave (
        input  time_now, sym_in, sym_valid,
        output dt_out, weight_out, tap_valid, n_live, overflow
    );

endinterface

// File: rtl/tx_edge_hist_tap.sv
// One history tap: holds an edge entry, retires it once settled, and registers its pwl operands.
module tx_edge_hist_tap
    import tx_edge_hist_pkg::*;
#(
    parameter int                         DT_WIDTH = EDGE_DT_WIDTH,
    parameter logic [EDGE_TIME_WIDTH-1:0] DT_MAX   = EDGE_DT_MAX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [EDGE_TIME_WIDTH-1:0] time_now,
    input  edge_entry_t                shift_in,
    output edge_entry_t                fwd,
    output logic                       nxt_valid,
    output logic [DT_WIDTH-1:0]        dt,
    output logic [EDGE_SYM_WIDTH:0]    weight,
    output logic                       valid
);

    edge_entry_t                ent;
    edge_entry_t                nxt;
    logic [EDGE_TIME_WIDTH-1:0] age;
    logic                       expired_now;
    logic [DT_WIDTH-1:0]        nxt_dt;

    assign age         = time_now - ent.stamp;
    assign expired_now = ent.valid && (age >= DT_MAX);

    // The copy handed to the next tap is already retired, so push and expiry compose.
    always_comb begin
        fwd       = ent;
        fwd.valid = ent.valid & ~expired_now;
    end

    assign nxt       = push ? shift_in : fwd;
    assign nxt_valid = nxt.valid;
    assign nxt_dt    = DT_WIDTH'(time_now - nxt.stamp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent    <= '0;
            dt     <= '0;
            weight <= '0;
            valid  <= 1'b0;
        end else begin
            ent    <= nxt;
            valid  <= nxt.valid;
            dt     <= nxt.valid ? nxt_dt : '0;
            weight <= nxt.valid ? nxt.weight : '0;
        end
    end

endmodule

// File: rtl/tx_edge_hist.sv
// Transmit edge history: detects symbol transitions and keeps DEPTH time-stamped step weights.
module tx_edge_hist
    import tx_edge_hist_pkg::*;
#(
    parameter int                         DEPTH    = EDGE_HIST_DEPTH,
    parameter int                         DT_WIDTH = EDGE_DT_WIDTH,
    parameter logic [EDGE_TIME_WIDTH-1:0] DT_MAX   = EDGE_DT_MAX
) (
    input  logic           clk,
    input  logic           rst,
    tx_edge_hist_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W_W   = EDGE_SYM_WIDTH + 1;

    logic [EDGE_SYM_WIDTH-1:0] last_sym;
    logic                      push;
    logic                      overflow_q;
    logic [CNT_W-1:0]          n_live_q;
    logic [CNT_W-1:0]          live_cnt;
    logic [DEPTH-1:0]          nxt_valid;
    logic [DEPTH-1:0]          tap_valid;
    logic [DT_WIDTH-1:0]       tap_dt     [DEPTH];
    logic [W_W-1:0]            tap_weight [DEPTH];
    edge_entry_t               head;
    edge_entry_t               fwd        [DEPTH];

    assign push = bus.sym_valid && (bus.sym_in != last_sym);

    always_comb begin
        head.stamp  = bus.time_now;
        head.weight = step_weight(bus.sym_in, last_sym);
        head.valid  = 1'b1;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_tap
        edge_entry_t shift_in;

        if (k == 0) begin : g_head
            assign shift_in = head;
        end else begin : g_shift
            assign shift_in = fwd[k-1];
        end

        tx_edge_hist_tap #(
            .DT_WIDTH (DT_WIDTH),
            .DT_MAX   (DT_MAX)
        ) u_tap (
            .clk       (clk),
            .rst       (rst),
            .push      (push),
            .time_now  (bus.time_now),
            .shift_in  (shift_in),
            .fwd       (fwd[k]),
            .nxt_valid (nxt_valid[k]),
            .dt        (tap_dt[k]),
            .weight    (tap_weight[k]),
            .valid     (tap_valid[k])
        );

        assign bus.dt_out[k*DT_WIDTH +: DT_WIDTH] = tap_dt[k];
        assign bus.weight_out[k*W_W +: W_W]       = tap_weight[k];
    end

    always_comb begin
        live_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            live_cnt = live_cnt + CNT_W'(nxt_valid[k]);
        end
    end

    // Only a still-live oldest entry being shoved out counts as lost history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sym   <= '0;
            overflow_q <= 1'b0;
            n_live_q   <= '0;
        end else begin
            if (push) begin
                last_sym <= bus.sym_in;
            end
            if (push && fwd[DEPTH-1].valid) begin
                overflow_q <= 1'b1;
            end
            n_live_q <= live_cnt;
        end
    end

    assign bus.tap_valid = tap_valid;
    assign bus.n_live    = n_live_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_tx_edge_hist.sv
// Directed bench for tx_edge_hist with DEPTH=8, DT_WIDTH=20, DT_MAX=64.
module tb_tx_edge_hist;
    import tx_edge_hist_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] now;
    int          errors = 0;
    int          checks = 0;

    tx_edge_hist_if #(.DEPTH(8), .DT_WIDTH(20)) bus ();

    tx_edge_hist #(
        .DEPTH    (8),
        .DT_WIDTH (20),
        .DT_MAX   (32'd64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] dt_of(input int k);
        return bus.dt_out[k*20 +: 20];
    endfunction

    function automatic logic [2:0] w_of(input int k);
        return bus.weight_out[k*3 +: 3];
    endfunction

    task automatic cyc(input logic v, input logic [1:0] s);
        bus.time_now  = now;
        bus.sym_valid = v;
        bus.sym_in    = s;
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
        now = now + 1;
    endtask

    task automatic do_reset();
        bus.sym_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.time_now  = 32'd0;
        bus.sym_in    = 2'd0;
        bus.sym_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.tap_valid !== 8'h00) begin errors++; $display("FAIL reset_tap_valid got=%h want=00", bus.tap_valid); end
        checks++; if (bus.dt_out !== 160'd0) begin errors++; $display("FAIL reset_dt_out got=%h want=0", bus.dt_out); end
        checks++; if (bus.weight_out !== 24'd0) begin errors++; $display("FAIL reset_weight_out got=%h want=0", bus.weight_out); end
        checks++; if (bus.n_live !== 4'd0) begin errors++; $display("FAIL reset_n_live got=%0d want=0", bus.n_live); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_edge();
        do_reset();
        now = 32'd100;
        cyc(1'b1, 2'd3);
        checks++; if (bus.tap_valid !== 8'h01) begin errors++; $display("FAIL edge_tap_valid got=%h want=01", bus.tap_valid); end
        checks++; if (w_of(0) !== 3'b011) begin errors++; $display("FAIL edge_weight0 got=%b want=011", w_of(0)); end
        checks++; if (dt_of(0) !== 20'd0) begin errors++; $display("FAIL edge_dt0_first got=%0d want=0", dt_of(0)); end
        for (int i = 0; i < 50; i++) cyc(1'b0, 2'd3);
        checks++; if (dt_of(0) !== 20'd50) begin errors++; $display("FAIL edge_dt0_t150 got=%0d want=50", dt_of(0)); end
        checks++; if (bus.n_live !== 4'd1) begin errors++; $display("FAIL edge_n_live got=%0d want=1", bus.n_live); end
    endtask

    task automatic test_no_edge();
        cyc(1'b1, 2'd3);
        checks++; if (bus.tap_valid !== 8'h01) begin errors++; $display("FAIL repeat_tap_valid got=%h want=01", bus.tap_valid); end
        checks++; if (dt_of(0) !== 20'd51) begin errors++; $display("FAIL repeat_dt0 got=%0d want=51", dt_of(0)); end
        checks++; if (w_of(0) !== 3'b011) begin errors++; $display("FAIL repeat_weight0 got=%b want=011", w_of(0)); end
        checks++; if (bus.n_live !== 4'd1) begin errors++; $display("FAIL repeat_n_live got=%0d want=1", bus.n_live); end
    endtask

    task automatic test_expiry();
        do_reset();
        now = 32'd10;
        cyc(1'b1, 2'd2);
        for (int i = 0; i < 9; i++) cyc(1'b0, 2'd2);
        cyc(1'b1, 2'd1);
        for (int i = 0; i < 53; i++) cyc(1'b0, 2'd1);
        checks++; if (bus.tap_valid !== 8'h03) begin errors++; $display("FAIL exp_t73_tap_valid got=%h want=03", bus.tap_valid); end
        checks++; if (dt_of(1) !== 20'd63) begin errors++; $display("FAIL exp_t73_dt1 got=%0d want=63", dt_of(1)); end
        checks++; if (dt_of(0) !== 20'd53) begin errors++; $display("FAIL exp_t73_dt0 got=%0d want=53", dt_of(0)); end
        checks++; if (bus.n_live !== 4'd2) begin errors++; $display("FAIL exp_t73_n_live got=%0d want=2", bus.n_live); end
        cyc(1'b0, 2'd1);
        checks++; if (bus.tap_valid !== 8'h01) begin errors++; $display("FAIL exp_t74_tap_valid got=%h want=01", bus.tap_valid); end
        checks++; if (dt_of(1) !== 20'd0) begin errors++; $display("FAIL exp_t74_dt1 got=%0d want=0", dt_of(1)); end
        checks++; if (w_of(1) !== 3'b000) begin errors++; $display("FAIL exp_t74_weight1 got=%b want=000", w_of(1)); end
        checks++; if (w_of(0) !== 3'b111) begin errors++; $display("FAIL exp_t74_weight0 got=%b want=111", w_of(0)); end
        checks++; if (bus.n_live !== 4'd1) begin errors++; $display("FAIL exp_t74_n_live got=%0d want=1", bus.n_live); end
        for (int i = 0; i < 9; i++) cyc(1'b0, 2'd1);
        checks++; if (dt_of(0) !== 20'd63) begin errors++; $display("FAIL exp_t83_dt0 got=%0d want=63", dt_of(0)); end
        cyc(1'b1, 2'd3);
        checks++; if (bus.tap_valid !== 8'h01) begin errors++; $display("FAIL exp_push_tap_valid got=%h want=01", bus.tap_valid); end
        checks++; if (w_of(0) !== 3'b010) begin errors++; $display("FAIL exp_push_weight0 got=%b want=010", w_of(0)); end
        checks++; if (w_of(1) !== 3'b000) begin errors++; $display("FAIL exp_push_weight1 got=%b want=000", w_of(1)); end
        checks++; if (bus.n_live !== 4'd1) begin errors++; $display("FAIL exp_push_n_live got=%0d want=1", bus.n_live); end
    endtask

    task automatic test_wrap();
        do_reset();
        now = 32'hFFFF_FFF0;
        cyc(1'b1, 2'd1);
        for (int i = 0; i < 32; i++) cyc(1'b0, 2'd1);
        checks++; if (dt_of(0) !== 20'd32) begin errors++; $display("FAIL wrap_dt0 got=%0d want=32", dt_of(0)); end
        checks++; if (w_of(0) !== 3'b001) begin errors++; $display("FAIL wrap_weight0 got=%b want=001", w_of(0)); end
        checks++; if (bus.tap_valid !== 8'h01) begin errors++; $display("FAIL wrap_tap_valid got=%h want=01", bus.tap_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        now = 32'd1000;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 2'd3 : 2'd0);
            if (i == 7) begin
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_push8_overflow got=%b want=0", bus.overflow); end
                checks++; if (bus.n_live !== 4'd8) begin errors++; $display("FAIL ovf_push8_n_live got=%0d want=8", bus.n_live); end
            end
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_push9_overflow got=%b want=1", bus.overflow); end
        checks++; if (bus.tap_valid !== 8'hFF) begin errors++; $display("FAIL ovf_push9_tap_valid got=%h want=ff", bus.tap_valid); end
        for (int i = 0; i < 70; i++) cyc(1'b0, 2'd3);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
        checks++; if (bus.n_live !== 4'd0) begin errors++; $display("FAIL ovf_drain_n_live got=%0d want=0", bus.n_live); end
    endtask

    task automatic test_no_overflow();
        do_reset();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL noovf_reset_clears got=%b want=0", bus.overflow); end
        now = 32'd2000;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 2'd3 : 2'd0);
            if (i == 8) begin
                checks++; if (bus.n_live !== 4'd1) begin errors++; $display("FAIL noovf_last_n_live got=%0d want=1", bus.n_live); end
            end
            for (int j = 0; j < 99; j++) cyc(1'b0, 2'd0);
        end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL noovf_overflow got=%b want=0", bus.overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        now = 32'd500;
        cyc(1'b1, 2'd1);
        cyc(1'b1, 2'd2);
        cyc(1'b1, 2'd3);
        checks++; if (bus.n_live !== 4'd3) begin errors++; $display("FAIL mid_pre_n_live got=%0d want=3", bus.n_live); end
        checks++; if (dt_of(2) !== 20'd2) begin errors++; $display("FAIL mid_pre_dt2 got=%0d want=2", dt_of(2)); end
        rst = 1'b1;
        #1;
        checks++; if (bus.tap_valid !== 8'h00) begin errors++; $display("FAIL mid_async_tap_valid got=%h want=00", bus.tap_valid); end
        checks++; if (bus.dt_out !== 160'd0) begin errors++; $display("FAIL mid_async_dt_out got=%h want=0", bus.dt_out); end
        checks++; if (bus.weight_out !== 24'd0) begin errors++; $display("FAIL mid_async_weight_out got=%h want=0", bus.weight_out); end
        checks++; if (bus.n_live !== 4'd0) begin errors++; $display("FAIL mid_async_n_live got=%0d want=0", bus.n_live); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 2'd0);
        checks++; if (bus.tap_valid !== 8'h00) begin errors++; $display("FAIL mid_sym0_tap_valid got=%h want=00", bus.tap_valid); end
        cyc(1'b1, 2'd2);
        checks++; if (bus.tap_valid !== 8'h01) begin errors++; $display("FAIL mid_sym2_tap_valid got=%h want=01", bus.tap_valid); end
        checks++; if (w_of(0) !== 3'b010) begin errors++; $display("FAIL mid_sym2_weight0 got=%b want=010", w_of(0)); end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_no_edge();
        test_expiry();
        test_wrap();
        test_overflow();
        test_no_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
